// File: rtl/rv32i_fetch_pkg.sv
// rv32i_fetch_pkg
//   Shared types and constants for the RV32I instruction fetch stage.
//   XLEN / ILEN : address and instruction widths (32).
//   PC_STEP     : sequential PC increment in bytes.
//   fetch_entry_t : one buffered instruction, {addr, data}.
package rv32i_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Synchronous FIFO parameterised by depth (power of 2) and entry type.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset
//     flush       : empties the FIFO; wins over a same-cycle push/pop
//     push, push_data : write an entry (ignored when full)
//     pop         : retire the head entry (ignored when empty)
//     head        : current head entry
//     empty       : FIFO holds no entries
//     count       : number of stored entries (0..DEPTH)
module fetch_fifo
  import rv32i_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T               mem_q [DEPTH];
  T               mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           push_en;
  logic           pop_en;

  assign push_en = push && (count_q != FULL_CNT);
  assign pop_en  = pop && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_en && !pop_en) begin
        count_d = count_q + (AW + 1)'(1);
      end else if (!push_en && pop_en) begin
        count_d = count_q - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit
//   Instruction fetch stage for the RV32I core. Keeps the PC, issues in-order
//   word requests to instruction memory, buffers returned words with their
//   addresses, and handles redirects by flushing and dropping stale responses.
//   Parameters: RESET_PC (PC after reset), FIFO_DEPTH (buffer entries and
//   outstanding-request cap, power of 2, >= 2).
//   Ports:
//     sysclk, sysreset           : clock, synchronous active-low reset
//     imem_req_valid/ready/addr  : request channel to instruction memory
//     imem_rsp_valid/data        : in-order response channel (no back-pressure)
//     inst_valid/ready, inst, inst_addr : instruction delivery to the core
//     redirect_valid, redirect_pc: branch/jump/trap redirect
//     fetch_fault                : sticky misaligned-redirect flag, present only
//                                  when FETCH_MISALIGN_CHK_EN is defined
module rv32i_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            sysclk,
  input  logic            sysreset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     credit_used;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_take;
  logic            tag_empty;
  logic [XLEN-1:0] tag_head;
  logic            buf_push;
  logic            buf_pop;
  logic            buf_empty;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_in;
  logic [XLEN-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & ~32'd3;

  // Credit only counts registered occupancy, so the request path never sees
  // redirect_valid or inst_ready combinationally.
  assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
  assign credit_ok   = (credit_used < DEPTH_W);

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault    = fault_q;
  assign imem_req_valid = credit_ok & ~fault_q;
`else
  assign imem_req_valid = credit_ok;
`endif

  assign imem_req_addr = pc_q;
  assign req_fire      = imem_req_valid & imem_req_ready;

  // A response with nothing tracked is a memory protocol error; ignore it.
  assign rsp_take = imem_rsp_valid & ~tag_empty;
  assign buf_push = rsp_take & (drop_q == '0);
  assign buf_pop  = inst_valid & inst_ready;
  assign buf_in   = '{addr: tag_head, data: imem_rsp_data};

  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !rsp_take) begin
      outstanding_next = outstanding + CW'(1);
    end else if (!req_fire && rsp_take) begin
      outstanding_next = outstanding - CW'(1);
    end
  end

  // Redirect overrides everything: after it, every response still in flight
  // (including one requested this cycle) belongs to the old stream.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (req_fire) begin
      pc_d = pc_q + PC_STEP;
    end
    if (rsp_take && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (redirect_valid) begin
      pc_d   = redirect_pc_aligned;
      drop_d = outstanding_next;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // Address tags of accepted requests; never flushed so that responses to be
  // dropped still retire their tag in order. Its occupancy is the outstanding
  // request count.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_tag_queue (
    .clk       (sysclk),
    .rst_n     (sysreset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_take),
    .head      (tag_head),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_inst_buf (
    .clk       (sysclk),
    .rst_n     (sysreset),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign inst_valid = ~buf_empty;
  assign inst       = inst_valid ? buf_head.data : '0;
  assign inst_addr  = inst_valid ? buf_head.addr : '0;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit
//   Self-checking bench for rv32i_fetch_unit. A behavioural instruction memory
//   returns f(addr) after a random latency; the expected delivered stream is
//   "consecutive words starting at the last redirect target (or RESET_PC)",
//   kept as a queue of segment start addresses filled by the stimulus and
//   consumed by an independent monitor. Build with FETCH_MISALIGN_CHK_EN
//   defined to also cover the fetch_fault port.
module tb_rv32i_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        sysclk;
  logic        sysreset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_fault;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int deliveries = 0;

  int readyPct = 100;
  int latMin = 1;
  int latMax = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ [$];
  logic [31:0] segQ [$];

  rv32i_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sysclk         (sysclk),
    .sysreset       (sysreset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_addr      (inst_addr),
    .redirect_valid (redirect_valid),
`ifdef FETCH_MISALIGN_CHK_EN
    .fetch_fault    (fetch_fault),
`endif
    .redirect_pc    (redirect_pc)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Drive core-side inputs for one cycle, just after the rising edge.
  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
    @(posedge sysclk);
    #1;
    inst_ready     = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (redir) segQ.push_back(rpc & ~32'd3);
  endtask

  // Two reset edges, check reset values, then release with the given inst_ready.
  task automatic resetDut(input logic readyAfter);
    @(posedge sysclk);
    #1;
    sysreset       = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    checkOutput("reset_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("reset_req_addr", imem_req_addr, RESET_PC);
    checkOutput("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("reset_inst", inst, 32'd0);
    checkOutput("reset_inst_addr", inst_addr, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("reset_fetch_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    @(posedge sysclk);
    #1;
    sysreset   = 1'b1;
    inst_ready = readyAfter;
  endtask

  // Behavioural instruction memory: in-order, latency latMin..latMax cycles.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge sysclk);
      if (!sysreset) begin
        memQ.delete();
      end else begin
        if (imem_rsp_valid && memQ.size() > 0) void'(memQ.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          checkOutput("req_addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
          memQ.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(latMax, latMin))});
          checkOutput("outstanding_cap", {31'd0, (memQ.size() <= DEPTH)}, 32'd1);
        end
      end
      @(posedge sysclk);
      cyc++;
      #1;
      imem_req_ready = ($urandom_range(99, 0) < readyPct);
      if (sysreset && memQ.size() > 0 && memQ[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memWord(memQ[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor: every delivered instruction must be the next word of the
  // current segment; held outputs must stay stable; redirect empties output.
  initial begin
    logic [31:0] expPc;
    logic        prevHold;
    logic        prevRedirect;
    logic [31:0] prevInst;
    logic [31:0] prevAddr;
    expPc        = RESET_PC;
    prevHold     = 1'b0;
    prevRedirect = 1'b0;
    prevInst     = '0;
    prevAddr     = '0;
    forever begin
      @(negedge sysclk);
      if (!sysreset) begin
        expPc        = RESET_PC;
        prevHold     = 1'b0;
        prevRedirect = 1'b0;
        segQ.delete();
      end else begin
        if (prevRedirect) checkOutput("valid_after_redirect", {31'd0, inst_valid}, 32'd0);
        if (prevHold) begin
          checkOutput("hold_valid", {31'd0, inst_valid}, 32'd1);
          checkOutput("hold_inst", inst, prevInst);
          checkOutput("hold_addr", inst_addr, prevAddr);
        end
        if (inst_valid && inst_ready) begin
          checkOutput("stream_addr", inst_addr, expPc);
          checkOutput("stream_data", inst, memWord(expPc));
          expPc = expPc + 32'd4;
          deliveries++;
        end
        prevHold     = inst_valid && !inst_ready && !redirect_valid;
        prevInst     = inst;
        prevAddr     = inst_addr;
        prevRedirect = redirect_valid;
        if (redirect_valid && segQ.size() > 0) expPc = segQ.pop_front();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstValid;
    int validCnt;
    int reqCnt;
    int startDel;
    int got;
    logic [31:0] seen [3];
    logic [31:0] target;

    sysreset       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge sysclk);

    $display("[TB] phase: reset release, k=1, streaming");
    readyPct = 100; latMin = 1; latMax = 1;
    resetDut(1'b1);
    firstValid = -1;
    validCnt   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclk);
      if (inst_valid && firstValid < 0) firstValid = i;
      if (i >= 2 && inst_valid) validCnt++;
    end
    checkOutput("first_valid_cycle", firstValid, 32'd2);
    checkOutput("stream_throughput", validCnt, 32'd6);

    $display("[TB] phase: back-pressure");
    resetDut(1'b0);
    reqCnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      if (imem_req_valid && imem_req_ready) reqCnt++;
    end
    checkOutput("bp_req_count", reqCnt, 32'd4);
    checkOutput("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("bp_head_addr", inst_addr, 32'h0);
    checkOutput("bp_head_data", inst, memWord(32'h0));
    startDel = deliveries;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, '0);
    @(negedge sysclk);
    checkOutput("bp_release_drained", {31'd0, (deliveries - startDel >= 4)}, 32'd1);

    $display("[TB] phase: redirect with stale responses, k=3");
    latMin = 3; latMax = 3;
    resetDut(1'b1);
    repeat (2) @(negedge sysclk);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    applyStimulus(1'b1, 1'b0, '0);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge sysclk);
      if (inst_valid) begin
        got = 1;
        checkOutput("redirect_first_addr", inst_addr, 32'h0000_0100);
      end
    end
    checkOutput("redirect_wait", got, 32'd1);

    $display("[TB] phase: redirect with same-cycle request and response, k=1");
    latMin = 1; latMax = 1;
    resetDut(1'b1);
    repeat (5) @(negedge sysclk);
    applyStimulus(1'b1, 1'b1, 32'h0000_2000);
    applyStimulus(1'b1, 1'b0, '0);
    @(negedge sysclk);
    checkOutput("redir_r1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("redir_r1_req_addr", imem_req_addr, 32'h0000_2000);
    @(negedge sysclk);
    checkOutput("redir_r2_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge sysclk);
    checkOutput("redir_r3_valid", {31'd0, inst_valid}, 32'd1);
    checkOutput("redir_r3_addr", inst_addr, 32'h0000_2000);

    $display("[TB] phase: PC wrap");
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(1'b1, 1'b0, '0);
    got = 0;
    for (int i = 0; i < 30 && got < 3; i++) begin
      @(negedge sysclk);
      if (inst_valid && inst_ready) begin
        seen[got] = inst_addr;
        got++;
      end
    end
    checkOutput("wrap_count", got, 32'd3);
    if (got == 3) begin
      checkOutput("wrap_addr0", seen[0], 32'hFFFF_FFF8);
      checkOutput("wrap_addr1", seen[1], 32'hFFFF_FFFC);
      checkOutput("wrap_addr2", seen[2], 32'h0000_0000);
    end

    $display("[TB] phase: randomized traffic");
    readyPct = 70; latMin = 1; latMax = 4;
    resetDut(1'b1);
    startDel = deliveries;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) resetDut(1'b1);
      target = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
      target[1:0] = 2'b00;
`endif
      applyStimulus($urandom_range(3, 0) != 0, $urandom_range(99, 0) < 4, target);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, '0);
    @(negedge sysclk);
    checkOutput("random_progress", {31'd0, (deliveries - startDel > 200)}, 32'd1);

    $display("[TB] phase: misaligned redirect");
    readyPct = 100; latMin = 1; latMax = 1;
    resetDut(1'b1);
    repeat (3) @(negedge sysclk);
    applyStimulus(1'b1, 1'b1, 32'h0000_0102);
    applyStimulus(1'b1, 1'b0, '0);
`ifdef FETCH_MISALIGN_CHK_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      checkOutput("fault_flag", {31'd0, fetch_fault}, 32'd1);
      checkOutput("fault_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    resetDut(1'b1);
    @(negedge sysclk);
    checkOutput("fault_cleared_req_valid", {31'd0, imem_req_valid}, 32'd1);
`else
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge sysclk);
      if (inst_valid) begin
        got = 1;
        checkOutput("misalign_forced_addr", inst_addr, 32'h0000_0100);
      end
    end
    checkOutput("misalign_wait", got, 32'd1);
`endif

    repeat (2) @(negedge sysclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
